// File: rtl/det_pkg.sv
// Shared definitions for the determinant engine front end: widths, state
// encodings and small address/header helpers used by det_matrix_loader.
package det_pkg;

    localparam int DW    = 20;                     // element / read_data width
    localparam int MAX_N = 8;                      // largest supported dimension
    localparam int AW    = $clog2(MAX_N * MAX_N);  // RAM address width
    localparam int NW    = $clog2(MAX_N + 1);      // width holding 0..MAX_N
    localparam int IW    = 20;                     // engine index width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SERVE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } det_state_e;

    // Header values below 1 map to 1, above MAX_N map to MAX_N.
    function automatic logic [NW-1:0] clamp_n(input logic [DW-1:0] w);
        if ($signed(w) < 1)
            return NW'(1);
        else if ($signed(w) > MAX_N)
            return NW'(MAX_N);
        else
            return w[NW-1:0];
    endfunction

    // A header is out of range when it is not in [1, MAX_N].
    function automatic logic hdr_bad(input logic [DW-1:0] w);
        return ($signed(w) < 1) || ($signed(w) > MAX_N);
    endfunction

    // Row-major address; with r, c < n <= MAX_N the result fits in AW bits.
    function automatic logic [AW-1:0] calc_addr(input logic [NW-1:0] r,
                                                 input logic [NW-1:0] c,
                                                 input logic [NW-1:0] n);
        logic [AW-1:0] a;
        a = AW'(r) * AW'(n) + AW'(c);
        return a;
    endfunction

endpackage

// File: rtl/det_matrix_ram.sv
// MAX_N*MAX_N x DW register file: synchronous write, asynchronous read.
// Contents are never cleared; only addresses below N*N are meaningful.
module det_matrix_ram
    import det_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [MAX_N*MAX_N];

    // Write port: one element per accepted stream word.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/det_matrix_loader.sv
// Upstream stage of the determinant engine. Loads "N, then N*N elements"
// from a valid/ready stream into det_matrix_ram, releases the engine and
// serves its (i,j) reads; the first read after release returns N.
// Optional macro: DETLD_HDR_CHECK_EN -- out-of-range headers trap in ST_ERR
// (sticky err, exit only via reset) instead of being clamped.
// Handshake: a word transfers on a rising edge where in_valid & in_ready;
// in_ready does not depend on in_valid and is low while reset is asserted.
module det_matrix_loader
    import det_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    input  logic          read,
    output logic [DW-1:0] read_data,
    input  logic          finish,
    output logic          det_rst,
    output logic          loaded,
    output logic          err,
    output det_state_e    state
);

    det_state_e    cur_state, nxt_state;
    logic [NW-1:0] n_q, row_q, col_q;
    logic          hdr_pending_q;
    logic          ready_st, xfer, hdr_ok, accept_hdr, last_elem, load_xfer;
    logic          in_range;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] rdata;

    assign in_ready   = ready_st & ~reset;
    assign xfer       = in_valid & in_ready;
    assign accept_hdr = (cur_state == ST_IDLE || cur_state == ST_DONE) && xfer && hdr_ok;
    assign load_xfer  = (cur_state == ST_LOAD) && xfer;
    assign last_elem  = (row_q == n_q - NW'(1)) && (col_q == n_q - NW'(1));
    assign state      = cur_state;

`ifdef DETLD_HDR_CHECK_EN
    logic err_q;
    assign hdr_ok = ~hdr_bad(in_data);
    assign err    = err_q;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if ((cur_state == ST_IDLE || cur_state == ST_DONE) && xfer && !hdr_ok)
            err_q <= 1'b1;
    end
`else
    assign hdr_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            cur_state <= ST_IDLE;
        else
            cur_state <= nxt_state;
    end

    // Next-state and per-state outputs.
    always_comb begin
        nxt_state = cur_state;
        ready_st  = 1'b0;
        det_rst   = 1'b1;
        loaded    = 1'b0;
        case (cur_state)
            ST_IDLE, ST_DONE: begin
                ready_st = 1'b1;
                if (xfer)
                    nxt_state = hdr_ok ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
                ready_st = 1'b1;
                if (xfer && last_elem)
                    nxt_state = ST_SERVE;
            end
            ST_SERVE: begin
                det_rst = 1'b0;
                loaded  = 1'b1;
                if (finish)
                    nxt_state = ST_DONE;
            end
            ST_ERR: begin
                ready_st = 1'b1;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Dimension register and row/col load counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (accept_hdr) begin
            n_q   <= clamp_n(in_data);
            row_q <= '0;
            col_q <= '0;
        end else if (load_xfer) begin
            if (col_q == n_q - NW'(1)) begin
                col_q <= '0;
                row_q <= row_q + NW'(1);
            end else begin
                col_q <= col_q + NW'(1);
            end
        end
    end

    // First engine read after release returns N instead of RAM data.
    always_ff @(posedge clk) begin
        if (reset)
            hdr_pending_q <= 1'b0;
        else if (load_xfer && last_elem)
            hdr_pending_q <= 1'b1;
        else if (cur_state == ST_SERVE && read)
            hdr_pending_q <= 1'b0;
    end

    assign waddr    = calc_addr(row_q, col_q, n_q);
    assign raddr    = calc_addr(i[NW-1:0], j[NW-1:0], n_q);
    assign in_range = (i < IW'(n_q)) && (j < IW'(n_q));

    // Read mux: pending header, in-range element, or zero.
    always_comb begin
        read_data = '0;
        if (hdr_pending_q)
            read_data = DW'(n_q);
        else if (in_range)
            read_data = rdata;
    end

    det_matrix_ram u_ram (
        .clk   (clk),
        .we    (load_xfer),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
